// File: rtl/timer_mmio_pkg.sv
// =============================================================================
// Module  : timer_mmio_pkg
// Purpose : Register offsets, control bit positions and address decode for
//           the memory-mapped timer.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

package timer_mmio_pkg;

    localparam logic [31:0] TIMER_ADDR_TICKS_LO  = 32'h00;
    localparam logic [31:0] TIMER_ADDR_TICKS_HI  = 32'h04;
    localparam logic [31:0] TIMER_ADDR_MS_LO     = 32'h08;
    localparam logic [31:0] TIMER_ADDR_MS_HI     = 32'h0C;
    localparam logic [31:0] TIMER_ADDR_CMP_LO    = 32'h10;
    localparam logic [31:0] TIMER_ADDR_CMP_HI    = 32'h14;
    localparam logic [31:0] TIMER_ADDR_CTRL      = 32'h18;
    localparam logic [31:0] TIMER_ADDR_STATUS    = 32'h1C;
    localparam logic [31:0] TIMER_ADDR_PERIOD_LO = 32'h20;
    localparam logic [31:0] TIMER_ADDR_PERIOD_HI = 32'h24;

    localparam int TIMER_CTRL_IRQ_EN = 0;
    localparam int TIMER_CTRL_SRC    = 1;

    localparam logic [63:0] TIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [3:0] {
        REG_TICKS_LO,
        REG_TICKS_HI,
        REG_MS_LO,
        REG_MS_HI,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_CTRL,
        REG_STATUS,
        REG_PERIOD_LO,
        REG_PERIOD_HI,
        REG_NONE
    } reg_e;

    // Decode a word index (byte address >> 2) into a register select.
    function automatic reg_e timer_decode(input logic [29:0] word);
        reg_e sel;
        sel = REG_NONE;
        case (word)
            TIMER_ADDR_TICKS_LO[31:2]:  sel = REG_TICKS_LO;
            TIMER_ADDR_TICKS_HI[31:2]:  sel = REG_TICKS_HI;
            TIMER_ADDR_MS_LO[31:2]:     sel = REG_MS_LO;
            TIMER_ADDR_MS_HI[31:2]:     sel = REG_MS_HI;
            TIMER_ADDR_CMP_LO[31:2]:    sel = REG_CMP_LO;
            TIMER_ADDR_CMP_HI[31:2]:    sel = REG_CMP_HI;
            TIMER_ADDR_CTRL[31:2]:      sel = REG_CTRL;
            TIMER_ADDR_STATUS[31:2]:    sel = REG_STATUS;
            TIMER_ADDR_PERIOD_LO[31:2]: sel = REG_PERIOD_LO;
            TIMER_ADDR_PERIOD_HI[31:2]: sel = REG_PERIOD_HI;
            default:                    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_mmio_ms_sampler.sv
// =============================================================================
// Module  : ms_sampler
// Purpose : Brings the quasi-static millisecond count into the core clock
//           domain; the output only moves once two samples agree.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module ms_sampler (
    input  logic        core_clock,
    input  logic        reset,
    input  logic [63:0] miliseconds,
    output logic [63:0] ms_stable
);

    logic [63:0] ms_q1;
    logic [63:0] ms_q2;
    logic [63:0] ms_stable_q;
    logic [63:0] ms_stable_d;

    // A mismatch means the foreign counter was caught mid-transition.
    assign ms_stable_d = (ms_q1 == ms_q2) ? ms_q2 : ms_stable_q;

    always_ff @(posedge core_clock or posedge reset) begin
        if (reset) begin
            ms_q1       <= '0;
            ms_q2       <= '0;
            ms_stable_q <= '0;
        end else begin
            ms_q1       <= miliseconds;
            ms_q2       <= ms_q1;
            ms_stable_q <= ms_stable_d;
        end
    end

    assign ms_stable = ms_stable_q;

endmodule

`default_nettype wire

// File: rtl/timer_mmio.sv
// =============================================================================
// Module  : timer_mmio
// Purpose : 32-bit MMIO view of the 64-bit tick/ms counters with tear-free
//           snapshots, 64-bit compare and level interrupt. Optional periodic
//           reload with sticky pending under `TIMER_AUTO_RELOAD_EN.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module timer_mmio
    import timer_mmio_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [63:0] CMP_RESET = TIMER_CMP_RESET
) (
    input  logic              core_clock,
    input  logic              reset,
    input  logic [63:0]       core_clock_ticks,
    input  logic [63:0]       miliseconds,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              timer_interrupt
);

    logic [31:0] read_data_q;
    logic        read_valid_q;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] cmp_lo_shadow_q;
    logic [1:0]  ctrl_q;
    logic [31:0] ticks_hi_snap_q;
    logic [31:0] ms_hi_snap_q;
    logic        pending_q, pending_d;

    logic [63:0] w_ms_stable;
    logic [29:0] w_word;
    reg_e        w_reg;
    logic [31:0] w_rdata;
    logic [63:0] w_count;
    logic        w_hit;
    logic        w_unused;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [63:0] period_q;
    logic [31:0] period_lo_shadow_q;
    logic        w_clr;
`endif

    ms_sampler u_ms_sampler (
        .core_clock  (core_clock),
        .reset       (reset),
        .miliseconds (miliseconds),
        .ms_stable   (w_ms_stable)
    );

    assign w_word   = 30'(address[ADDR_W-1:2]);
    assign w_reg    = timer_decode(w_word);
    assign w_unused = &{1'b0, address[1:0]};

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_TICKS_LO:  w_rdata = core_clock_ticks[31:0];
            REG_TICKS_HI:  w_rdata = ticks_hi_snap_q;
            REG_MS_LO:     w_rdata = w_ms_stable[31:0];
            REG_MS_HI:     w_rdata = ms_hi_snap_q;
            REG_CMP_LO:    w_rdata = cmp_q[31:0];
            REG_CMP_HI:    w_rdata = cmp_q[63:32];
            REG_CTRL:      w_rdata = {30'b0, ctrl_q};
            REG_STATUS:    w_rdata = {31'b0, pending_q};
`ifdef TIMER_AUTO_RELOAD_EN
            REG_PERIOD_LO: w_rdata = period_q[31:0];
            REG_PERIOD_HI: w_rdata = period_q[63:32];
`endif
            default:       w_rdata = '0;
        endcase
    end

    assign w_count = ctrl_q[TIMER_CTRL_SRC] ? w_ms_stable : core_clock_ticks;
    assign w_hit   = (w_count >= cmp_q);

`ifdef TIMER_AUTO_RELOAD_EN
    assign w_clr = mem_write && (w_reg == REG_STATUS) && write_data[0];
`endif

    // A software commit of CMP_HI takes priority over an automatic reload.
    always_comb begin
        cmp_d     = cmp_q;
        pending_d = w_hit;
        if (mem_write && (w_reg == REG_CMP_HI)) begin
            cmp_d = {write_data, cmp_lo_shadow_q};
        end
`ifdef TIMER_AUTO_RELOAD_EN
        else if (w_hit && !pending_q && (period_q != '0)) begin
            cmp_d = cmp_q + period_q;
        end
        pending_d = w_hit | (pending_q & ~w_clr);
`endif
    end

    always_ff @(posedge core_clock or posedge reset) begin
        if (reset) begin
            read_data_q     <= '0;
            read_valid_q    <= 1'b0;
            cmp_q           <= CMP_RESET;
            cmp_lo_shadow_q <= '0;
            ctrl_q          <= '0;
            ticks_hi_snap_q <= '0;
            ms_hi_snap_q    <= '0;
            pending_q       <= 1'b0;
        end else begin
            read_valid_q <= mem_read;
            read_data_q  <= mem_read ? w_rdata : '0;
            cmp_q        <= cmp_d;
            pending_q    <= pending_d;
            if (mem_read && (w_reg == REG_TICKS_LO)) begin
                ticks_hi_snap_q <= core_clock_ticks[63:32];
            end
            if (mem_read && (w_reg == REG_MS_LO)) begin
                ms_hi_snap_q <= w_ms_stable[63:32];
            end
            if (mem_write && (w_reg == REG_CMP_LO)) begin
                cmp_lo_shadow_q <= write_data;
            end
            if (mem_write && (w_reg == REG_CTRL)) begin
                ctrl_q <= write_data[1:0];
            end
        end
    end

`ifdef TIMER_AUTO_RELOAD_EN
    always_ff @(posedge core_clock or posedge reset) begin
        if (reset) begin
            period_q           <= '0;
            period_lo_shadow_q <= '0;
        end else begin
            if (mem_write && (w_reg == REG_PERIOD_LO)) begin
                period_lo_shadow_q <= write_data;
            end
            if (mem_write && (w_reg == REG_PERIOD_HI)) begin
                period_q <= {write_data, period_lo_shadow_q};
            end
        end
    end
`endif

    assign read_data       = read_data_q;
    assign read_valid      = read_valid_q;
    assign timer_interrupt = pending_q & ctrl_q[TIMER_CTRL_IRQ_EN];

endmodule

`default_nettype wire

// File: tb/tb_timer_mmio.sv
// =============================================================================
// Module  : tb_timer_mmio
// Purpose : Self-checking bench for timer_mmio: directed scenarios plus a
//           randomized bus/counter phase checked against a register model.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_timer_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ticks;
    logic [63:0] ms;
    logic [5:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    always #5 clk = ~clk;

    timer_mmio #(
        .ADDR_W    (6),
        .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .core_clock       (clk),
        .reset            (rst),
        .core_clock_ticks (ticks),
        .miliseconds      (ms),
        .address          (addr),
        .mem_read         (rd),
        .mem_write        (wr),
        .write_data       (wdata),
        .read_data        (rdata),
        .read_valid       (rvalid),
        .timer_interrupt  (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural register contents.
    logic [63:0] m_cmp;
    logic [31:0] m_cmp_shadow;
    logic [1:0]  m_ctrl;
    logic [63:0] m_stable;
    logic [63:0] m_seen1;   // ms value sampled one edge ago
    logic [63:0] m_seen2;   // ms value sampled two edges ago
    logic [31:0] m_tsnap;
    logic [31:0] m_msnap;
    logic        m_pend;
    logic [63:0] m_period;
    logic [31:0] m_pshadow;

    task automatic model_reset();
        m_cmp        = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cmp_shadow = '0;
        m_ctrl       = '0;
        m_stable     = '0;
        m_seen1      = '0;
        m_seen2      = '0;
        m_tsnap      = '0;
        m_msnap      = '0;
        m_pend       = 1'b0;
        m_period     = '0;
        m_pshadow    = '0;
    endtask

    function automatic logic [31:0] m_read(input int word);
        case (word)
            0:       return ticks[31:0];
            1:       return m_tsnap;
            2:       return m_stable[31:0];
            3:       return m_msnap;
            4:       return m_cmp[31:0];
            5:       return m_cmp[63:32];
            6:       return {30'b0, m_ctrl};
            7:       return {31'b0, m_pend};
`ifdef TIMER_AUTO_RELOAD_EN
            8:       return m_period[31:0];
            9:       return m_period[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model over one clock edge, take the edge, then compare.
    task automatic step();
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        hit;
        logic        rise;
        logic        clr;
        logic [63:0] ncmp;
        int          w;
        exp_rv = 1'b0;
        exp_rd = '0;
        if (rst) begin
            model_reset();
        end else begin
            w      = int'(addr[5:2]);
            exp_rv = rd;
            exp_rd = rd ? m_read(w) : 32'h0;
            hit    = ((m_ctrl[1] ? m_stable : ticks) >= m_cmp);
            rise   = hit && !m_pend;
            clr    = wr && (w == 7) && wdata[0];
            if (rd && w == 0) m_tsnap = ticks[63:32];
            if (rd && w == 2) m_msnap = m_stable[63:32];
            ncmp = m_cmp;
            if (wr && w == 5) ncmp = {wdata, m_cmp_shadow};
`ifdef TIMER_AUTO_RELOAD_EN
            else if (rise && m_period != 0) ncmp = m_cmp + m_period;
            m_pend = hit | (m_pend & !clr);
            if (wr && w == 9) m_period = {wdata, m_pshadow};
            if (wr && w == 8) m_pshadow = wdata;
`else
            m_pend = hit;
            if (rise && clr) m_pend = hit;
`endif
            m_cmp = ncmp;
            if (wr && w == 4) m_cmp_shadow = wdata;
            if (wr && w == 6) m_ctrl = wdata[1:0];
            // ms only advances once two consecutive samples agree
            if (m_seen1 == m_seen2) m_stable = m_seen2;
            m_seen2 = m_seen1;
            m_seen1 = ms;
        end
        @(posedge clk);
        #1;
        chk("read_valid", {63'b0, rvalid}, {63'b0, exp_rv});
        if (exp_rv) chk($sformatf("read_data@%02h", addr), {32'b0, rdata}, {32'b0, exp_rd});
        chk("timer_interrupt", {63'b0, irq}, {63'b0, m_pend & m_ctrl[0]});
    endtask

    task automatic bus_read(input logic [5:0] a);
        rd = 1'b1; addr = a;
        step();
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step();
        wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ticks = '0; ms = '0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        step();
        step();
        rst = 1'b0;
        bus_read(6'h18);
        chk("ctrl_after_reset", {32'b0, rdata}, 64'h0);

        // Reset asserted in the middle of an outstanding read
        rd = 1'b1; addr = 6'h10;
        step();
        #2 rst = 1'b1;
        step();
        chk("rv_mid_reset", {63'b0, rvalid}, 64'h0);
        rd = 1'b0; rst = 1'b0;
        bus_read(6'h10);
        chk("cmp_lo_reset", {32'b0, rdata}, 64'hFFFF_FFFF);
        bus_read(6'h14);
        chk("cmp_hi_reset", {32'b0, rdata}, 64'hFFFF_FFFF);

        // Tear-free 64-bit tick read across a 32-bit carry
        ticks = 64'h0000_0001_FFFF_FFFE;
        bus_read(6'h00);
        chk("ticks_lo", {32'b0, rdata}, 64'hFFFF_FFFE);
        ticks = 64'h0000_0002_0000_0005;
        bus_read(6'h04);
        chk("ticks_hi_snap", {32'b0, rdata}, 64'h1);

        // Compare crossing and wrap
        ticks = 64'hF0;
        bus_write(6'h18, 32'h1);
        bus_write(6'h10, 32'h100);
        step();
        chk("irq_after_cmp_lo_only", {63'b0, irq}, 64'h0);
        bus_write(6'h14, 32'h0);
        for (int v = 'hF8; v <= 'h102; v++) begin
            ticks = 64'(v);
            step();
            chk("irq_cross", {63'b0, irq}, {63'b0, v >= 'h100});
        end
        ticks = 64'h0;
        step();
        chk("irq_wrap", {63'b0, irq}, 64'h0);

        // ms filtering: constantly changing input must not move ms_stable
        for (int i = 0; i < 6; i++) begin
            ms = 64'(1000 + i);
            step();
        end
        bus_read(6'h08);
        chk("ms_lo_unstable", {32'b0, rdata}, 64'h0);
        ms = 64'd42;
        step(); step(); step();
        bus_read(6'h08);
        chk("ms_lo_42", {32'b0, rdata}, 64'd42);
        bus_read(6'h0C);
        chk("ms_hi_42", {32'b0, rdata}, 64'h0);

        // Simultaneous read and write of CTRL
        bus_write(6'h18, 32'h0);
        rd = 1'b1; wr = 1'b1; addr = 6'h18; wdata = 32'h3;
        step();
        rd = 1'b0; wr = 1'b0;
        chk("ctrl_rw_old", {32'b0, rdata}, 64'h0);
        bus_read(6'h18);
        chk("ctrl_rw_new", {32'b0, rdata}, 64'h3);
        bus_read(6'h20);
`ifndef TIMER_AUTO_RELOAD_EN
        chk("period_lo_absent", {32'b0, rdata}, 64'h0);
`endif

`ifdef TIMER_AUTO_RELOAD_EN
        rst = 1'b1; step(); rst = 1'b0;
        ticks = '0;
        bus_write(6'h20, 32'd10);
        bus_write(6'h24, 32'd0);
        bus_write(6'h10, 32'd100);
        bus_write(6'h14, 32'd0);
        bus_write(6'h18, 32'h1);
        for (int v = 96; v <= 105; v++) begin
            ticks = 64'(v);
            step();
        end
        bus_read(6'h10);
        chk("reload_cmp", {32'b0, rdata}, 64'd110);
        bus_read(6'h1C);
        chk("sticky_pending", {32'b0, rdata}, 64'h1);
        bus_write(6'h1C, 32'h1);
        bus_read(6'h1C);
        chk("pending_cleared", {32'b0, rdata}, 64'h0);
`endif

        // Randomized phase
        for (int c = 0; c < 2000; c++) begin
            int r;
            int op;
            int wsel;
            r = int'($urandom_range(0, 99));
            if (r < 85)      ticks = ticks + 64'($urandom_range(0, 3));
            else if (r < 92) ticks = m_cmp - 64'($urandom_range(0, 8));
            else if (r < 97) ticks = {32'($urandom_range(0, 3)), 32'hFFFF_FFFA};
            else             ticks = '0;
            r = int'($urandom_range(0, 99));
            if (r < 10)      ms = {32'($urandom_range(0, 2)), $urandom};
            else if (r < 15) ms = m_cmp - 64'($urandom_range(0, 6));
            wsel = int'($urandom_range(0, 15));
            addr = 6'(wsel * 4 + int'($urandom_range(0, 3)));
            case (wsel)
                4:       wdata = ticks[31:0] + 32'($urandom_range(0, 40));
                5:       wdata = ticks[63:32];
                default: wdata = $urandom;
            endcase
            op = int'($urandom_range(0, 9));
            rd = (op <= 3) || (op == 7);
            wr = (op >= 4) && (op <= 7);
            step();
        end
        rd = 1'b0; wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
